// File: rtl/decoder_ls_shift_pipe.sv
// Registered RV32I/RV64I load/store/shift decoder behind a valid/ready handshake.
// SKID=1 adds a second holding register so in_ready_o comes straight from a flop.
module decoder_ls_shift_pipe #(
  parameter int unsigned XLEN = 32,
  parameter bit          SKID = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [31:0]               in_instr_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      is_load_o,
  output logic                      is_store_o,
  output logic                      is_shift_o,
  output logic                      shift_left_o,
  output logic                      shift_arithmetic_o,
  output logic                      shift_immediate_o,
  output logic [1:0]                mem_size_o,
  output logic                      mem_unsigned_o,
  output logic                      illegal_o,
  output logic [4:0]                rs1_o,
  output logic [4:0]                rs2_o,
  output logic [4:0]                rd_o,
  output logic [XLEN-1:0]           immediate_o,
  output logic [$clog2(XLEN)-1:0]   shamt_o
);

  localparam int unsigned SW = $clog2(XLEN);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam bit         RV64     = (XLEN == 64);

  typedef struct packed {
    logic            is_load;
    logic            is_store;
    logic            is_shift;
    logic            shift_left;
    logic            shift_arithmetic;
    logic            shift_immediate;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic            illegal;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] immediate;
    logic [SW-1:0]   shamt;
  } dec_t;

  dec_t       dec;
  dec_t       out_q;
  dec_t       skid_q;
  logic       out_valid_q;
  logic       skid_valid_q;
  logic       in_fire;
  logic       out_free;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [6:0] shift_hi;
  logic [6:0] srai_hi;
  logic [5:0] shamt_raw;

  assign funct3 = in_instr_i[14:12];
  assign funct7 = in_instr_i[31:25];
  // RV64 immediate shifts borrow bit 25 for the shamt, leaving a 6-bit funct field
  assign shift_hi  = RV64 ? {1'b0, in_instr_i[31:26]} : in_instr_i[31:25];
  assign srai_hi   = RV64 ? 7'b0010000 : 7'b0100000;
  assign shamt_raw = RV64 ? in_instr_i[25:20] : {1'b0, in_instr_i[24:20]};

  // Combinational decode of the word being offered
  always_comb begin
    dec     = '0;
    dec.rs1 = in_instr_i[19:15];
    dec.rs2 = in_instr_i[24:20];
    dec.rd  = in_instr_i[11:7];
    case (in_instr_i[6:0])
      OP_LOAD: begin
        dec.immediate = {{(XLEN-12){in_instr_i[31]}}, in_instr_i[31:20]};
        if (funct3 == 3'b111 || (!RV64 && (funct3 == 3'b011 || funct3 == 3'b110))) begin
          dec.illegal = 1'b1;
        end else begin
          dec.is_load      = 1'b1;
          dec.mem_size     = funct3[1:0];
          dec.mem_unsigned = funct3[2];
        end
      end
      OP_STORE: begin
        dec.immediate = {{(XLEN-12){in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
        if (funct3[2] || (!RV64 && funct3 == 3'b011)) begin
          dec.illegal = 1'b1;
        end else begin
          dec.is_store = 1'b1;
          dec.mem_size = funct3[1:0];
        end
      end
      OP_REG: begin
        if (funct3 == 3'b001) begin
          if (funct7 == 7'b0000000) begin
            dec.is_shift   = 1'b1;
            dec.shift_left = 1'b1;
          end else begin
            dec.illegal = 1'b1;
          end
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
            dec.is_shift         = 1'b1;
            dec.shift_arithmetic = funct7[5];
          end else begin
            dec.illegal = 1'b1;
          end
        end
      end
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec.shamt     = SW'(shamt_raw);
          dec.immediate = XLEN'(shamt_raw);
          if (shift_hi == 7'b0000000) begin
            dec.is_shift        = 1'b1;
            dec.shift_immediate = 1'b1;
            dec.shift_left      = ~funct3[2];
          end else if (funct3 == 3'b101 && shift_hi == srai_hi) begin
            dec.is_shift         = 1'b1;
            dec.shift_immediate  = 1'b1;
            dec.shift_arithmetic = 1'b1;
          end else begin
            dec.illegal = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign out_free   = !out_valid_q || out_ready_i;
  assign in_ready_o = !rst_i && (SKID ? !skid_valid_q : out_free);
  assign in_fire    = in_valid_i && in_ready_o;

  // Output stage plus skid entry; the skid entry always drains ahead of new input
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (flush_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= in_fire;
        if (in_fire) out_q <= dec;
      end
    end else if (in_fire) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid_o        = out_valid_q;
  assign is_load_o          = out_q.is_load;
  assign is_store_o         = out_q.is_store;
  assign is_shift_o         = out_q.is_shift;
  assign shift_left_o       = out_q.shift_left;
  assign shift_arithmetic_o = out_q.shift_arithmetic;
  assign shift_immediate_o  = out_q.shift_immediate;
  assign mem_size_o         = out_q.mem_size;
  assign mem_unsigned_o     = out_q.mem_unsigned;
  assign illegal_o          = out_q.illegal;
  assign rs1_o              = out_q.rs1;
  assign rs2_o              = out_q.rs2;
  assign rd_o               = out_q.rd;
  assign immediate_o        = out_q.immediate;
  assign shamt_o            = out_q.shamt;

endmodule

// File: tb/tb_decoder_ls_shift_pipe.sv
// Bench for decoder_ls_shift_pipe: an RV32/skid instance and an RV64/no-skid instance
// share one stimulus stream and are each checked against a queue-based reference model.
module tb_decoder_ls_shift_pipe;

  typedef struct packed {
    logic        is_load;
    logic        is_store;
    logic        is_shift;
    logic        shift_left;
    logic        shift_arithmetic;
    logic        shift_immediate;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        illegal;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic [5:0]  shamt;
  } dec_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;

  logic out_valid_a, in_ready_a, is_load_a, is_store_a, is_shift_a, sl_a, sa_a, si_a, uns_a, ill_a;
  logic [1:0] size_a;
  logic [4:0] rs1_a, rs2_a, rd_a, shamt_a;
  logic [31:0] imm_a;
  logic out_valid_b, in_ready_b, is_load_b, is_store_b, is_shift_b, sl_b, sa_b, si_b, uns_b, ill_b;
  logic [1:0] size_b;
  logic [4:0] rs1_b, rs2_b, rd_b;
  logic [5:0] shamt_b;
  logic [63:0] imm_b;

  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  dec_t obs_a, obs_b;

  always #5 clk = ~clk;

  decoder_ls_shift_pipe #(.XLEN(32), .SKID(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_a),
    .in_instr_i(in_instr), .out_valid_o(out_valid_a), .out_ready_i(out_ready),
    .is_load_o(is_load_a), .is_store_o(is_store_a), .is_shift_o(is_shift_a),
    .shift_left_o(sl_a), .shift_arithmetic_o(sa_a), .shift_immediate_o(si_a),
    .mem_size_o(size_a), .mem_unsigned_o(uns_a), .illegal_o(ill_a),
    .rs1_o(rs1_a), .rs2_o(rs2_a), .rd_o(rd_a), .immediate_o(imm_a), .shamt_o(shamt_a));

  decoder_ls_shift_pipe #(.XLEN(64), .SKID(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_b),
    .in_instr_i(in_instr), .out_valid_o(out_valid_b), .out_ready_i(out_ready),
    .is_load_o(is_load_b), .is_store_o(is_store_b), .is_shift_o(is_shift_b),
    .shift_left_o(sl_b), .shift_arithmetic_o(sa_b), .shift_immediate_o(si_b),
    .mem_size_o(size_b), .mem_unsigned_o(uns_b), .illegal_o(ill_b),
    .rs1_o(rs1_b), .rs2_o(rs2_b), .rd_o(rd_b), .immediate_o(imm_b), .shamt_o(shamt_b));

  assign obs_a = {is_load_a, is_store_a, is_shift_a, sl_a, sa_a, si_a, size_a, uns_a, ill_a,
                  rs1_a, rs2_a, rd_a, 64'(imm_a), 6'(shamt_a)};
  assign obs_b = {is_load_b, is_store_b, is_shift_b, sl_b, sa_b, si_b, size_b, uns_b, ill_b,
                  rs1_b, rs2_b, rd_b, imm_b, shamt_b};

  // Reference decode straight from the ISA rules, widened to 64-bit immediate / 6-bit shamt
  function automatic dec_t mdec(input logic [31:0] ins, input int xlen);
    dec_t d;
    int f3, f7, hi, amt;
    longint ii, si;
    d = '0;
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    d.rs1 = ins[19:15];
    d.rs2 = ins[24:20];
    d.rd  = ins[11:7];
    ii = longint'($signed(ins[31:20]));
    si = longint'($signed({ins[31:25], ins[11:7]}));
    if (xlen == 32) begin
      ii = ii & 64'h0000_0000_FFFF_FFFF;
      si = si & 64'h0000_0000_FFFF_FFFF;
    end
    case (ins[6:0])
      7'b0000011: begin
        d.imm = 64'(ii);
        if (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5 || (xlen == 64 && (f3 == 3 || f3 == 6))) begin
          d.is_load = 1'b1;
          d.mem_size = 2'(f3 % 4);
          d.mem_unsigned = (f3 >= 4);
        end else d.illegal = 1'b1;
      end
      7'b0100011: begin
        d.imm = 64'(si);
        if (f3 < 3 || (xlen == 64 && f3 == 3)) begin
          d.is_store = 1'b1;
          d.mem_size = 2'(f3);
        end else d.illegal = 1'b1;
      end
      7'b0110011: begin
        if (f3 == 1) begin
          if (f7 == 0) begin d.is_shift = 1'b1; d.shift_left = 1'b1; end
          else d.illegal = 1'b1;
        end else if (f3 == 5) begin
          if (f7 == 0) d.is_shift = 1'b1;
          else if (f7 == 32) begin d.is_shift = 1'b1; d.shift_arithmetic = 1'b1; end
          else d.illegal = 1'b1;
        end
      end
      7'b0010011: begin
        if (f3 == 1 || f3 == 5) begin
          amt = int'(ins[24:20]) + ((xlen == 64) ? 32 * int'(ins[25]) : 0);
          hi  = (xlen == 64) ? int'(ins[31:26]) : int'(ins[31:25]);
          d.shamt = 6'(amt);
          d.imm   = 64'(amt);
          if (hi == 0) begin
            d.is_shift = 1'b1; d.shift_immediate = 1'b1; d.shift_left = (f3 == 1);
          end else if (f3 == 5 && hi == ((xlen == 64) ? 16 : 32)) begin
            d.is_shift = 1'b1; d.shift_immediate = 1'b1; d.shift_arithmetic = 1'b1;
          end else d.illegal = 1'b1;
        end
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: w[6:0] = 7'b0000011;
      1: w[6:0] = 7'b0100011;
      2: w[6:0] = 7'b0110011;
      3, 4: w[6:0] = 7'b0010011;
      default: ;
    endcase
    if ($urandom_range(0, 2) != 0) w[31:26] = ($urandom_range(0, 1) != 0) ? 6'h00 : 6'h10;
    if ($urandom_range(0, 3) == 0) w[25] = 1'b0;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_out_valid", 128'(out_valid_a), 128'(qa.size() > 0));
    chk("a_in_ready", 128'(in_ready_a), 128'(qa.size() < 2));
    if (qa.size() > 0) chk("a_fields", 128'(obs_a), 128'(mdec(qa[0], 32)));
    chk("b_out_valid", 128'(out_valid_b), 128'(qb.size() > 0));
    chk("b_in_ready", 128'(in_ready_b), 128'(qb.size() == 0 || out_ready));
    if (qb.size() > 0) chk("b_fields", 128'(obs_b), 128'(mdec(qb[0], 64)));
  endtask

  // One clock: check pre-edge state, advance model at the edge, return 1 time unit after it
  task automatic cycle();
    logic fa, fb, pa, pb;
    #1;
    check_all();
    pa = (qa.size() > 0) && out_ready;
    fa = in_valid && (qa.size() < 2);
    pb = (qb.size() > 0) && out_ready;
    fb = in_valid && (qb.size() == 0 || out_ready);
    @(posedge clk);
    if (flush) begin
      qa.delete();
      qb.delete();
    end else begin
      if (pa) void'(qa.pop_front());
      if (fa) qa.push_back(in_instr);
      if (pb) void'(qb.pop_front());
      if (fb) qb.push_back(in_instr);
    end
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    in_valid = 1'b1;
    in_instr = w;
    out_ready = 1'b1;
    flush = 1'b0;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    #2;
    chk("rst_out_valid_a", 128'(out_valid_a), 128'(0));
    chk("rst_in_ready_a", 128'(in_ready_a), 128'(0));
    chk("rst_fields_a", 128'(obs_a), 128'(0));
    chk("rst_in_ready_b", 128'(in_ready_b), 128'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rel_in_ready_a", 128'(in_ready_a), 128'(1));
    chk("rel_in_ready_b", 128'(in_ready_b), 128'(1));

    // Directed decodes
    send(32'h0081_2283);
    chk("lw_load", 128'(is_load_a), 128'(1));
    chk("lw_size", 128'(size_a), 128'(2));
    chk("lw_uns", 128'(uns_a), 128'(0));
    chk("lw_rs1", 128'(rs1_a), 128'(2));
    chk("lw_rd", 128'(rd_a), 128'(5));
    chk("lw_imm", 128'(imm_a), 128'(8));
    chk("lw_ill", 128'(ill_a), 128'(0));
    send(32'hFE60_AE23);
    chk("sw_store", 128'(is_store_a), 128'(1));
    chk("sw_rs1", 128'(rs1_a), 128'(1));
    chk("sw_rs2", 128'(rs2_a), 128'(6));
    chk("sw_imm_a", 128'(imm_a), 128'(32'hFFFF_FFFC));
    chk("sw_imm_b", 128'(imm_b), 128'(64'hFFFF_FFFF_FFFF_FFFC));
    send(32'h0081_7283);
    chk("badld_ill", 128'(ill_a), 128'(1));
    chk("badld_load", 128'(is_load_a), 128'(0));
    send(32'h4072_5193);
    chk("srai_shift", 128'(is_shift_a), 128'(1));
    chk("srai_arith", 128'(sa_a), 128'(1));
    chk("srai_imm", 128'(si_a), 128'(1));
    chk("srai_shamt", 128'(shamt_a), 128'(7));
    send(32'h0200_9093);
    chk("slli32_ill_a", 128'(ill_a), 128'(1));
    chk("slli32_shift_a", 128'(is_shift_a), 128'(0));
    chk("slli32_ill_b", 128'(ill_b), 128'(0));
    chk("slli32_left_b", 128'(sl_b), 128'(1));
    chk("slli32_shamt_b", 128'(shamt_b), 128'(32));
    send(32'h0000_3083);
    chk("ld_ill_a", 128'(ill_a), 128'(1));
    chk("ld_size_b", 128'(size_b), 128'(3));
    cycle();

    // Backpressure: three words into a stalled consumer
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0000_2083;
    cycle();
    in_instr = 32'h0000_2103;
    cycle();
    chk("bp_hold1", 128'(rd_a), 128'(1));
    in_instr = 32'h0000_2183;
    #1;
    chk("bp_ready_drop", 128'(in_ready_a), 128'(0));
    cycle();
    chk("bp_hold2", 128'(rd_a), 128'(1));
    out_ready = 1'b1;
    cycle();
    chk("bp_order1", 128'(rd_a), 128'(2));
    cycle();
    chk("bp_order2", 128'(rd_a), 128'(3));
    in_valid = 1'b0;
    cycle();
    chk("bp_drain", 128'(out_valid_a), 128'(0));

    // Flush with one held entry and a simultaneous input handshake
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0000_2083;
    cycle();
    in_instr = 32'h0000_2103; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_out_valid", 128'(out_valid_a), 128'(0));
    out_ready = 1'b1;
    repeat (3) cycle();

    // Flush with output and skid both occupied
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0000_2083;
    cycle();
    in_instr = 32'h0000_2103;
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_out_valid", 128'(out_valid_a), 128'(0));
    out_ready = 1'b1;
    repeat (3) cycle();

    // Asynchronous reset with both entries full
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0000_2083;
    cycle();
    in_instr = 32'h0000_2103;
    cycle();
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid_a", 128'(out_valid_a), 128'(0));
    chk("arst_in_ready_a", 128'(in_ready_a), 128'(0));
    chk("arst_fields_a", 128'(obs_a), 128'(0));
    chk("arst_out_valid_b", 128'(out_valid_b), 128'(0));
    chk("arst_in_ready_b", 128'(in_ready_b), 128'(0));
    qa.delete();
    qb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("arst_rel_ready_a", 128'(in_ready_a), 128'(1));
    send(32'h0081_2283);
    chk("arst_post_lw", 128'(obs_a), 128'(mdec(32'h0081_2283, 32)));

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_instr  = rnd_instr();
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
